vec_ram_seq: RTL

//  Vector load/store sequencer for one port of the dual-port vector RAM. It accepts a burst

---
 rtl/vec_ram_seq_if.sv | 60 ++++++
 rtl/vec_ram_seq.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/vec_ram_seq_if.sv
// Bundle of every non-clock signal of the vector RAM load/store sequencer.
// The slave modport is the sequencer's view. The master modport is the view of
// whatever surrounds it: issue logic, stream producer/consumer and the RAM port.
interface vec_ram_seq_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6,
    parameter int LEN_WIDTH  = 7
);
    // Command channel
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_base;
    logic [LEN_WIDTH-1:0]  cmd_len;

    // Load stream (RAM -> consumer)
    logic                  rd_valid;
    logic                  rd_ready;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_last;

    // Store stream (producer -> RAM)
    logic                  wr_valid;
    logic                  wr_ready;
    logic [DATA_WIDTH-1:0] wr_data;

    // Status
    logic                  busy;
    logic                  done;

    // RAM port (synchronous read, one-cycle latency)
    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_din;
    logic [DATA_WIDTH-1:0] ram_dout;

    modport slave (
        input  cmd_valid, cmd_write, cmd_base, cmd_len,
        input  rd_ready,
        input  wr_valid, wr_data,
        input  ram_dout,
        output cmd_ready,
        output rd_valid, rd_data, rd_last,
        output wr_ready,
        output busy, done,
        output ram_we, ram_addr, ram_din
    );

    modport master (
        output cmd_valid, cmd_write, cmd_base, cmd_len,
        output rd_ready,
        output wr_valid, wr_data,
        output ram_dout,
        input  cmd_ready,
        input  rd_valid, rd_data, rd_last,
        input  wr_ready,
        input  busy, done,
        input  ram_we, ram_addr, ram_din
    );
endinterface

// File: rtl/vec_ram_seq.sv
// Vector load/store sequencer for one port of the dual-port vector RAM.
// It takes a burst command (base, length, direction). A load streams RAM
// elements out through a 2-entry output FIFO. A store writes stream elements
// straight into the RAM. Addresses wrap modulo the RAM depth.
module vec_ram_seq #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6,
    parameter int LEN_WIDTH  = 7
) (
    input  logic          clk,
    input  logic          rst,
    vec_ram_seq_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_STORE = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_nextState;

    // Burst context captured at command accept
    logic [ADDR_WIDTH-1:0] r_base;
    logic [LEN_WIDTH-1:0]  r_len;
    logic [LEN_WIDTH-1:0]  r_issued;
    logic [LEN_WIDTH-1:0]  r_xfer;

    // Read pipeline and output FIFO
    logic                  r_inflight;
    logic [DATA_WIDTH-1:0] r_fifo [2];
    logic                  r_wrPtr;
    logic                  r_rdPtr;
    logic [1:0]            r_count;

    logic                  r_done;

    // Combinational handshake and control terms
    logic                  w_idle;
    logic                  w_cmdFire;
    logic                  w_cmdLoad;
    logic                  w_cmdStore;
    logic                  w_cmdEmpty;
    logic                  w_lastIdx;
    logic                  w_rdValid;
    logic                  w_rdFire;
    logic                  w_rdLastFire;
    logic                  w_wrReady;
    logic                  w_wrFire;
    logic                  w_wrLastFire;
    logic [2:0]            w_occupancy;
    logic                  w_issueMore;
    logic                  w_issue;
    logic [ADDR_WIDTH-1:0] w_issueAddr;
    logic [ADDR_WIDTH-1:0] w_storeAddr;
    logic                  w_finish;

    // Decode the handshakes. The first read of a load is issued in the
    // command-accept cycle itself. That puts the first element on rd_valid
    // two cycles after the handshake. FIFO occupancy is counted after this
    // cycle's pop, so a consumer that is always ready sees one element per cycle.
    always_comb begin
        w_idle       = (r_state == S_IDLE);
        w_cmdFire    = bus.cmd_valid & w_idle;
        w_cmdLoad    = w_cmdFire & ~bus.cmd_write & (bus.cmd_len != '0);
        w_cmdStore   = w_cmdFire &  bus.cmd_write & (bus.cmd_len != '0);
        w_cmdEmpty   = w_cmdFire & (bus.cmd_len == '0);

        w_lastIdx    = (r_xfer == (r_len - LEN_WIDTH'(1)));

        w_rdValid    = (r_count != 2'd0);
        w_rdFire     = w_rdValid & bus.rd_ready;
        w_rdLastFire = w_rdFire & w_lastIdx;

        w_wrReady    = (r_state == S_STORE) & (r_xfer < r_len);
        w_wrFire     = w_wrReady & bus.wr_valid;
        w_wrLastFire = w_wrFire & w_lastIdx;

        w_occupancy  = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_rdFire};
        w_issueMore  = (r_state == S_LOAD) & (r_issued < r_len) & (w_occupancy < 3'd2);
        w_issue      = w_cmdLoad | w_issueMore;
        w_issueAddr  = w_cmdLoad ? bus.cmd_base : (r_base + ADDR_WIDTH'(r_issued));
        w_storeAddr  = r_base + ADDR_WIDTH'(r_xfer);

        w_finish     = w_cmdEmpty | w_rdLastFire | w_wrLastFire;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic. A zero-length command never leaves IDLE.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_cmdLoad) begin
                    w_nextState = S_LOAD;
                end else if (w_cmdStore) begin
                    w_nextState = S_STORE;
                end
            end
            S_LOAD: begin
                if (w_rdLastFire) begin
                    w_nextState = S_IDLE;
                end
            end
            S_STORE: begin
                if (w_wrLastFire) begin
                    w_nextState = S_IDLE;
                end
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    // Drive the outputs. The RAM port is held at zero whenever no read is
    // issued and no write handshakes, so an idle or zero-length burst shows
    // no address activity.
    always_comb begin
        bus.cmd_ready = w_idle;
        bus.rd_valid  = w_rdValid;
        bus.rd_data   = r_fifo[r_rdPtr];
        bus.rd_last   = w_rdValid & w_lastIdx;
        bus.wr_ready  = w_wrReady;
        bus.busy      = ~w_idle;
        bus.done      = r_done;
        bus.ram_we    = 1'b0;
        bus.ram_addr  = '0;
        bus.ram_din   = '0;
        if (w_wrFire) begin
            bus.ram_we   = 1'b1;
            bus.ram_addr = w_storeAddr;
            bus.ram_din  = bus.wr_data;
        end else if (w_issue) begin
            bus.ram_addr = w_issueAddr;
        end
    end

    // Burst counters, read-in-flight flag and done pulse. Reset drops any
    // in-flight read, so its data is never pushed.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_base     <= '0;
            r_len      <= '0;
            r_issued   <= '0;
            r_xfer     <= '0;
            r_inflight <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            r_done     <= w_finish;
            if (w_cmdFire) begin
                r_base   <= bus.cmd_base;
                r_len    <= bus.cmd_len;
                r_issued <= w_cmdLoad ? LEN_WIDTH'(1) : '0;
                r_xfer   <= '0;
            end else begin
                if (w_issueMore) begin
                    r_issued <= r_issued + LEN_WIDTH'(1);
                end
                if (w_rdFire | w_wrFire) begin
                    r_xfer <= r_xfer + LEN_WIDTH'(1);
                end
            end
        end
    end

    // Two-entry output FIFO. It is pushed with RAM data one cycle after each
    // read issue and popped on each rd handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                r_fifo[i] <= '0;
            end
            r_wrPtr <= 1'b0;
            r_rdPtr <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (r_inflight) begin
                r_fifo[r_wrPtr] <= bus.ram_dout;
                r_wrPtr         <= ~r_wrPtr;
            end
            if (w_rdFire) begin
                r_rdPtr <= ~r_rdPtr;
            end
            r_count <= r_count + {1'b0, r_inflight} - {1'b0, w_rdFire};
        end
    end

endmodule
